// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM state encoding
// and the number of input vectors swept.
package truth_table_sweeper_pkg;

   localparam int NUM_VECTORS = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle countdown: load reloads SETTLE-1, enable decrements toward zero,
// expired flags the edge on which the held vector is sampled.
module settle_timer #(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic reset_b,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = RELOAD;
      else if (enable && (cnt_q != 4'd0))
         cnt_d = cnt_q - 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_b)
         cnt_q <= 4'd0;
      else
         cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == 4'd0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 16 input vectors of a 4-input function, holding each for SETTLE
// cycles, and captures the observed truth table, its minterm count and a match flag.
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic        start,
   input  logic [15:0] expected,
   input  logic        f,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   output logic        busy,
   output logic        done,
   output logic [15:0] tt,
   output logic [4:0]  ones,
   output logic        match
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_VECTORS - 1);

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [15:0] tt_q, tt_d;
   logic [4:0]  ones_q, ones_d;
   logic        match_q, match_d;
   logic        tmr_load, tmr_en, tmr_expired;

   settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
      .clk     (clk),
      .reset_b (reset_b),
      .load    (tmr_load),
      .enable  (tmr_en),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tt_d     = tt_q;
      ones_d   = ones_q;
      match_d  = match_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               idx_d    = 4'd0;
               tt_d     = 16'h0000;
               ones_d   = 5'd0;
               match_d  = 1'b0;
               tmr_load = 1'b1;
            end
         end
         RUN: begin
            tmr_en = 1'b1;
            if (tmr_expired) begin
               tt_d[idx_q] = f;
               ones_d      = ones_q + {4'd0, f};
               // Compare against the table including this final capture.
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
                  match_d = (tt_d == expected);
               end else begin
                  idx_d    = idx_q + 4'd1;
                  tmr_load = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         tt_q    <= 16'h0000;
         ones_q  <= 5'd0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tt_q    <= tt_d;
         ones_q  <= ones_d;
         match_q <= match_d;
      end
   end

   assign busy         = (state_q == RUN);
   assign done         = (state_q == DONE);
   assign {a, b, c, d} = busy ? idx_q : 4'b0000;
   assign tt           = tt_q;
   assign ones         = ones_q;
   assign match        = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Three sweepers (SETTLE = 1, 2, 3) on one clock, each closing the loop through a
// bench-held function table; results checked against the table itself.
module tb_truth_table_sweeper;

   logic        clk = 1'b0;
   logic        reset_b;
   logic        start [3];
   logic [15:0] exp_v [3];
   logic [15:0] func  [3];
   logic        f_w   [3];
   logic        a_w [3], b_w [3], c_w [3], d_w [3];
   logic        busy_w [3], done_w [3], match_w [3];
   logic [15:0] tt_w [3];
   logic [4:0]  ones_w [3];

   int checks = 0;
   int errors = 0;

   localparam int SET [3] = '{1, 2, 3};

   always #5 clk = ~clk;

   // The function under sweep is simply a lookup into the bench's table.
   always_comb begin
      for (int i = 0; i < 3; i++)
         f_w[i] = func[i][{a_w[i], b_w[i], c_w[i], d_w[i]}];
   end

   truth_table_sweeper #(.SETTLE(1)) u_s1 (
      .clk(clk), .reset_b(reset_b), .start(start[0]), .expected(exp_v[0]), .f(f_w[0]),
      .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .d(d_w[0]), .busy(busy_w[0]), .done(done_w[0]),
      .tt(tt_w[0]), .ones(ones_w[0]), .match(match_w[0]));
   truth_table_sweeper #(.SETTLE(2)) u_s2 (
      .clk(clk), .reset_b(reset_b), .start(start[1]), .expected(exp_v[1]), .f(f_w[1]),
      .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .d(d_w[1]), .busy(busy_w[1]), .done(done_w[1]),
      .tt(tt_w[1]), .ones(ones_w[1]), .match(match_w[1]));
   truth_table_sweeper #(.SETTLE(3)) u_s3 (
      .clk(clk), .reset_b(reset_b), .start(start[2]), .expected(exp_v[2]), .f(f_w[2]),
      .a(a_w[2]), .b(b_w[2]), .c(c_w[2]), .d(d_w[2]), .busy(busy_w[2]), .done(done_w[2]),
      .tt(tt_w[2]), .ones(ones_w[2]), .match(match_w[2]));

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d @%0t: observed %0h expected %0h", tag, k, $time, obs, exp);
      end
   endtask

   function automatic logic [31:0] vec_of(input int k);
      return {28'd0, a_w[k], b_w[k], c_w[k], d_w[k]};
   endfunction

   task automatic chk_idle(input string tag, input int k);
      chk({tag, "_busy"}, k, busy_w[k], 0);
      chk({tag, "_done"}, k, done_w[k], 0);
      chk({tag, "_abcd"}, k, vec_of(k), 0);
   endtask

   // One full sweep. Edge 0 is the edge that samples start; observation after
   // edge n. Vector n/S is driven until the sweep ends after edge 16*S, done is
   // high for the single cycle leading up to edge 16*S+1.
   task automatic sweep(input int k, input logic [15:0] fn, input logic [15:0] ex, input bit poke);
      int s;
      int last;
      s = SET[k];
      last = 16 * s;
      @(negedge clk);
      func[k]  = fn;
      exp_v[k] = ex;
      start[k] = 1'b1;
      @(posedge clk); #1;
      start[k] = 1'b0;
      for (int n = 0; n <= last; n++) begin
         if (n < last) begin
            chk("run_busy", k, busy_w[k], 1);
            chk("run_done", k, done_w[k], 0);
            chk("run_abcd", k, vec_of(k), 32'(n / s));
         end else begin
            chk("fin_done", k, done_w[k], 1);
            chk("fin_busy", k, busy_w[k], 0);
            chk("fin_abcd", k, vec_of(k), 0);
            chk("fin_tt",   k, tt_w[k], {16'd0, fn});
            chk("fin_ones", k, ones_w[k], $countones(fn));
            chk("fin_match", k, match_w[k], (fn == ex) ? 1 : 0);
         end
         start[k] = poke && (n == 5 || n == last);
         // expected must be sampled only at completion: disturb it mid-sweep.
         if (n < last) exp_v[k] = 16'(ex ^ 16'hA5A5);
         else          exp_v[k] = 16'(~ex);
         if (n == last - 1) exp_v[k] = ex;
         @(posedge clk); #1;
      end
      start[k] = 1'b0;
      chk_idle("post", k);
      @(posedge clk); #1;
      chk_idle("hold", k);
      chk("hold_tt",    k, tt_w[k], {16'd0, fn});
      chk("hold_ones",  k, ones_w[k], $countones(fn));
      chk("hold_match", k, match_w[k], (fn == ex) ? 1 : 0);
   endtask

   initial begin
      logic [15:0] fn, ex;
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0;
         exp_v[i] = 16'h0000;
         func[i]  = 16'h0000;
      end
      // Reset held two cycles with start asserted: reset must win.
      reset_b  = 1'b0;
      start[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk_idle("rst", i);
         chk("rst_tt",    i, tt_w[i], 0);
         chk("rst_ones",  i, ones_w[i], 0);
         chk("rst_match", i, match_w[i], 0);
      end
      start[0] = 1'b0;
      reset_b  = 1'b1;
      @(posedge clk); #1;

      // Parity function, matching and non-matching reference.
      sweep(0, 16'h6996, 16'h6996, 1'b0);
      sweep(0, 16'h6996, 16'h0000, 1'b0);
      // start re-asserted during RUN and in the DONE cycle.
      sweep(1, 16'h6996, 16'h6996, 1'b1);
      // Constant-one function.
      sweep(2, 16'hFFFF, 16'hFFFF, 1'b0);

      // Reset mid-sweep while vector 7 is driven.
      @(negedge clk);
      func[1]  = 16'h1234;
      start[1] = 1'b1;
      @(posedge clk); #1;
      start[1] = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      chk("mid_abcd", 1, vec_of(1), 7);
      reset_b = 1'b0;
      @(posedge clk); #1;
      reset_b = 1'b1;
      chk_idle("midrst", 1);
      chk("midrst_tt",   1, tt_w[1], 0);
      chk("midrst_ones", 1, ones_w[1], 0);
      sweep(1, 16'h1234, 16'h1234, 1'b0);

      // Random functions; the reference equals the function half the time.
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 3; k++) begin
            fn = 16'($urandom);
            ex = $urandom_range(0, 1) ? fn : 16'($urandom);
            sweep(k, fn, ex, r[0]);
         end
      end
      sweep(0, 16'h0000, 16'h0000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
